noc_out_port_arbiter: RTL

Round-robin arbiter and single-flit output register for one switch output port (right, top or PE). It selects among up to N_REQ competing flit sources (left, bottom, PE), registers the winner, and holds it until downstream accepts. It turns the fixed-priority, drop-prone output muxing of the bufferless router into a fair, back-pressured handshake. One instance sits per output port inside the next-generation switch.

---
 rtl/noc_out_port_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/noc_out_port_arbiter.sv
// noc_out_port_arbiter: round-robin arbiter with a single-flit output register
// for one switch output port. It grants one requester per cycle and holds the
// registered flit until downstream accepts it.
// Optional macro AGE_PRIO_EN: per-requester age counters. A requester that has
// waited AGE_LIMIT cycles overrides the round-robin pointer.
module noc_out_port_arbiter #(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned data_width  = 8,
    parameter int unsigned x_size      = 2,
    parameter int unsigned y_size      = 2,
    parameter int unsigned total_width = 2*x_size + 2*y_size + data_width,
    parameter int unsigned AGE_LIMIT   = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             i_req,
    input  logic [N_REQ*total_width-1:0] i_data,
    output logic [N_REQ-1:0]             o_gnt,
    output logic                         o_valid,
    output logic [total_width-1:0]       o_data,
    input  logic                         i_ready,
    output logic [1:0]                   o_state,
    output logic [15:0]                  o_stall_cycles
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [total_width-1:0] data_q, data_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [15:0]            stall_q, stall_d;

    logic                   load;
    logic                   win_found;
    logic [PTR_W-1:0]       win_idx;
    logic [N_REQ-1:0]       gnt;
    logic                   any_gnt;
    logic [total_width-1:0] sel_data;
    logic [N_REQ-1:0]       aged;

`ifdef AGE_PRIO_EN
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0] age_q [N_REQ];
    logic [AGE_W-1:0] age_d [N_REQ];

    // Flag requesters still asking that have waited up to the age limit
    always_comb begin
        aged = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            aged[k] = i_req[k] && (age_q[k] == AGE_W'(AGE_LIMIT));
        end
    end

    // Age counts waiting cycles; cleared when granted or when the request drops
    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            age_d[k] = age_q[k];
            if (!i_req[k] || gnt[k]) begin
                age_d[k] = '0;
            end else if (age_q[k] != AGE_W'(AGE_LIMIT)) begin
                age_d[k] = age_q[k] + AGE_W'(1);
            end
        end
    end

    // Age counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                age_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                age_q[k] <= age_d[k];
            end
        end
    end
`else
    assign aged = '0;
`endif

    assign load = ~valid_q | i_ready;

    // Winner search: aged override first, else first request at or above ptr, else wrap to lowest
    always_comb begin
        logic             hi_found, lo_found, age_found;
        logic [PTR_W-1:0] hi_idx, lo_idx, age_idx;
        hi_found  = 1'b0;
        lo_found  = 1'b0;
        age_found = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        age_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (aged[k] && !age_found) begin
                age_found = 1'b1;
                age_idx   = PTR_W'(k);
            end
            if (i_req[k] && (k >= 32'(ptr_q)) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = PTR_W'(k);
            end
            if (i_req[k] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = PTR_W'(k);
            end
        end
        win_found = lo_found;
        if (age_found) begin
            win_idx = age_idx;
        end else if (hi_found) begin
            win_idx = hi_idx;
        end else begin
            win_idx = lo_idx;
        end
    end

    // One-hot grant and winner payload mux; suppressed in reset and while stalled
    always_comb begin
        gnt      = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            gnt[k] = rstn && load && win_found && (win_idx == PTR_W'(k));
            if (gnt[k]) begin
                sel_data = i_data[k*total_width +: total_width];
            end
        end
    end

    assign any_gnt = |gnt;

    // Next-state for output register, pointer, stall counter and FSM
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        state_d = state_q;

        if (load) begin
            valid_d = any_gnt;
        end
        if (any_gnt) begin
            data_d = sel_data;
            ptr_d  = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
        if (valid_q && !i_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end

        case (state_q)
            ST_IDLE:   state_d = any_gnt ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE,
            ST_HOLD: begin
                if (!i_ready) begin
                    state_d = ST_HOLD;
                end else if (any_gnt) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Registered state, output flit, pointer and stall counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            ptr_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
        end
    end

    assign o_gnt          = gnt;
    assign o_valid        = valid_q;
    assign o_data         = data_q;
    assign o_state        = state_q;
    assign o_stall_cycles = stall_q;

endmodule
